// File: rtl/tft_pkg.sv
// Shared constants and types for the parallel TFT bus target.
package tft_pkg;

  localparam logic [7:0] CMD_NOP   = 8'h00;
  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam logic [15:0] TFT_ID = 16'h9341;

  typedef enum logic [1:0] {
    IDLE,
    CASET,
    PASET,
    RAMWR
  } tft_state_e;

  localparam int STAT_NONEMPTY = 0;
  localparam int STAT_OVF      = 1;
  localparam int STAT_WERR     = 2;

endpackage

// File: rtl/tft_px_fifo.sv
// 4-deep pixel FIFO between bus decode and the framebuffer master.
module tft_px_fifo #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem_q [4];
  logic [W-1:0] mem_d [4];
  logic [1:0]   wptr_q, wptr_d;
  logic [1:0]   rptr_q, rptr_d;
  logic [2:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  assign full    = (cnt_q == 3'd4);
  assign empty   = (cnt_q == 3'd0);
  assign rdata   = mem_q[rptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) begin
      mem_d[wptr_q] = wdata;
      wptr_d = wptr_q + 2'd1;
    end
    if (do_pop) rptr_d = rptr_q + 2'd1;
    cnt_d = cnt_q + 3'(do_push) - 3'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/tft_bus_target.sv
// 8080-style TFT bus responder feeding a linear framebuffer.
// Optional read path: define TFT_TGT_READBACK_EN.
module tft_bus_target #(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int ADDR_W = 17
) (
  input  logic              csi_clk,
  input  logic              csi_reset_n,
  input  logic              lcd_cs_n,
  input  logic              lcd_wr_n,
  input  logic              lcd_rd_n,
  input  logic              lcd_rs,
  input  logic [15:0]       lcd_db_i,
  output logic [15:0]       lcd_db_o,
  output logic              lcd_db_oe,
  output logic [ADDR_W-1:0] fb_address,
  output logic [15:0]       fb_writedata,
  output logic              fb_write,
  input  logic              fb_waitrequest
);

  import tft_pkg::*;

  logic [1:0]  cs_sq, wr_sq, rs_sq;
  logic [15:0] db1_q, db2_q;
  logic        wr_prev_q;
  logic        cs_s, wr_s, rs_s;
  logic [15:0] db_s;
  logic        wr_evt;

  assign cs_s   = cs_sq[1];
  assign wr_s   = wr_sq[1];
  assign rs_s   = rs_sq[1];
  assign db_s   = db2_q;
  assign wr_evt = wr_s & ~wr_prev_q & ~cs_s;

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      cs_sq     <= 2'b11;
      wr_sq     <= 2'b11;
      rs_sq     <= 2'b00;
      db1_q     <= '0;
      db2_q     <= '0;
      wr_prev_q <= 1'b1;
    end else begin
      cs_sq     <= {cs_sq[0], lcd_cs_n};
      wr_sq     <= {wr_sq[0], lcd_wr_n};
      rs_sq     <= {rs_sq[0], lcd_rs};
      db1_q     <= lcd_db_i;
      db2_q     <= db1_q;
      wr_prev_q <= wr_s;
    end
  end

  tft_state_e  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] par_q, par_d;
  logic [15:0] sc_q, sc_d, ec_q, ec_d;
  logic [15:0] sp_q, sp_d, ep_q, ep_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic        ovf_q, ovf_d;
  logic        werr_q, werr_d;

  logic        fifo_push, fifo_full, fifo_empty;
  logic [ADDR_W-1:0] px_addr;
  logic [ADDR_W+15:0] fifo_rdata;
  logic [15:0] p_start, p_end, p_lim;
  logic        win_ok;
  logic        clr_flags;

  assign px_addr = ADDR_W'(y_q) * ADDR_W'(H_RES) + ADDR_W'(x_q);
  assign p_start = par_q[23:8];
  assign p_end   = {par_q[7:0], db_s[7:0]};
  assign p_lim   = (state_q == CASET) ? 16'(H_RES) : 16'(V_RES);
  assign win_ok  = (p_start <= p_end) && (p_end < p_lim);

`ifdef TFT_TGT_READBACK_EN
  logic [1:0]  rd_sq;
  logic        rd_prev_q;
  logic        rd_s, rd_fall, rd_rise;
  logic        stat_rd_q, stat_rd_d;
  logic [15:0] dbo_q, dbo_d;
  logic        oe_q, oe_d;
  logic [15:0] status;

  assign rd_s    = rd_sq[1];
  assign rd_fall = ~rd_s & rd_prev_q & ~cs_s;
  assign rd_rise = rd_s & ~rd_prev_q;

  always_comb begin
    status = '0;
    status[STAT_NONEMPTY] = ~fifo_empty;
    status[STAT_OVF]      = ovf_q;
    status[STAT_WERR]     = werr_q;
    dbo_d     = dbo_q;
    stat_rd_d = stat_rd_q;
    clr_flags = 1'b0;
    oe_d      = ~cs_s & ~rd_s;
    if (rd_fall) begin
      dbo_d     = rs_s ? TFT_ID : status;
      stat_rd_d = ~rs_s;
    end else if (rd_rise) begin
      clr_flags = stat_rd_q;
      stat_rd_d = 1'b0;
    end
  end

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      rd_sq     <= 2'b11;
      rd_prev_q <= 1'b1;
      stat_rd_q <= 1'b0;
      dbo_q     <= '0;
      oe_q      <= 1'b0;
    end else begin
      rd_sq     <= {rd_sq[0], lcd_rd_n};
      rd_prev_q <= rd_s;
      stat_rd_q <= stat_rd_d;
      dbo_q     <= dbo_d;
      oe_q      <= oe_d;
    end
  end

  assign lcd_db_o  = dbo_q;
  assign lcd_db_oe = oe_q;
`else
  logic unused_rd;
  assign unused_rd = lcd_rd_n;
  assign clr_flags = 1'b0;
  assign lcd_db_o  = '0;
  assign lcd_db_oe = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    par_d     = par_q;
    sc_d      = sc_q;
    ec_d      = ec_q;
    sp_d      = sp_q;
    ep_d      = ep_q;
    x_d       = x_q;
    y_d       = y_q;
    ovf_d     = ovf_q;
    werr_d    = werr_q;
    fifo_push = 1'b0;
    if (clr_flags) begin
      ovf_d  = 1'b0;
      werr_d = 1'b0;
    end
    if (wr_evt && !rs_s) begin
      unique case (db_s[7:0])
        CMD_CASET: begin
          state_d = CASET;
          idx_d   = '0;
        end
        CMD_PASET: begin
          state_d = PASET;
          idx_d   = '0;
        end
        CMD_RAMWR: begin
          state_d = RAMWR;
          x_d     = sc_q;
          y_d     = sp_q;
        end
        default: state_d = IDLE;
      endcase
    end else if (wr_evt) begin
      unique case (state_q)
        CASET, PASET: begin
          idx_d = idx_q + 2'd1;
          par_d = {par_q[15:0], db_s[7:0]};
          if (idx_q == 2'd3) begin
            state_d = IDLE;
            if (!win_ok) begin
              werr_d = 1'b1;
            end else if (state_q == CASET) begin
              sc_d = p_start;
              ec_d = p_end;
            end else begin
              sp_d = p_start;
              ep_d = p_end;
            end
          end
        end
        RAMWR: begin
          fifo_push = ~fifo_full;
          if (fifo_full) ovf_d = 1'b1;
          if (x_q != ec_q) begin
            x_d = x_q + 16'd1;
          end else begin
            x_d = sc_q;
            y_d = (y_q != ep_q) ? y_q + 16'd1 : sp_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      par_q   <= '0;
      sc_q    <= '0;
      ec_q    <= 16'(H_RES - 1);
      sp_q    <= '0;
      ep_q    <= 16'(V_RES - 1);
      x_q     <= '0;
      y_q     <= '0;
      ovf_q   <= 1'b0;
      werr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      sc_q    <= sc_d;
      ec_q    <= ec_d;
      sp_q    <= sp_d;
      ep_q    <= ep_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
      werr_q  <= werr_d;
    end
  end

  tft_px_fifo #(
    .W(ADDR_W + 16)
  ) u_fifo (
    .clk   (csi_clk),
    .rst_n (csi_reset_n),
    .push  (fifo_push),
    .pop   (fb_write & ~fb_waitrequest),
    .wdata ({px_addr, db_s}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign fb_write     = ~fifo_empty;
  assign fb_address   = fifo_rdata[ADDR_W+15:16];
  assign fb_writedata = fifo_rdata[15:0];

endmodule
